// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART framing stage.
package uart_frame_pkg;

   localparam logic [7:0]  SOF             = 8'hA5;
   localparam int unsigned DEFAULT_MAX_LEN = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, asynchronous read.
module uart_frame_buf #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem [DEPTH];

   // Contents carry no reset; they are only read after being written.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind the UART receiver: SOF, LEN, payload, XOR checksum, then drain.
// Define UART_FRAME_TIMEOUT_EN to build the inter-byte timeout that drops stalled frames.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int unsigned MAX_LEN        = DEFAULT_MAX_LEN,
   parameter int unsigned TIMEOUT_CYCLES = 24000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       rx_overrun,
   output logic       busy
);

   localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);
   localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] len_q, len_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [IDX_W-1:0] wr_next, rd_next;
   logic [7:0]       csum_q, csum_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             frame_ok_q, frame_ok_d;
   logic             frame_err_q, frame_err_d;
   logic             rx_overrun_q, rx_overrun_d;
   logic             busy_q;
   logic             buf_we;
   logic [ADDR_W-1:0] buf_raddr;
   logic [7:0]       buf_rdata;
   logic             tmo_expire;

   assign wr_next   = wr_idx_q + IDX_W'(1);
   assign rd_next   = rd_idx_q + IDX_W'(1);
   // Read port looks one byte ahead so the next output register load is ready on handshake.
   assign buf_raddr = (state_q == ST_DRAIN) ? ADDR_W'(rd_next) : '0;

   uart_frame_buf #(
      .DEPTH  (MAX_LEN),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (ADDR_W'(wr_idx_q)),
      .wdata (rx_data),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q;
   logic             tmo_active;

   assign tmo_active = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
   assign tmo_expire = tmo_active && !rx_valid && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Holds the number of cycles elapsed since the most recent strobe.
   always_ff @(posedge clk) begin
      if (reset)           tmo_cnt_q <= '0;
      else if (rx_valid)   tmo_cnt_q <= CNT_W'(1);
      else if (tmo_active) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      else                 tmo_cnt_q <= '0;
   end
`else
   assign tmo_expire = 1'b0;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      wr_idx_d     = wr_idx_q;
      rd_idx_d     = rd_idx_q;
      csum_d       = csum_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      frame_ok_d   = 1'b0;
      frame_err_d  = 1'b0;
      rx_overrun_d = 1'b0;
      buf_we       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid && rx_data == SOF) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (rx_valid) begin
               if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                  frame_err_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  len_d    = IDX_W'(rx_data);
                  csum_d   = rx_data;
                  wr_idx_d = '0;
                  state_d  = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (rx_valid) begin
               buf_we   = 1'b1;
               csum_d   = csum_q ^ rx_data;
               wr_idx_d = wr_next;
               if (wr_next == len_q) state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (rx_valid) begin
               if (rx_data == csum_q) begin
                  frame_ok_d  = 1'b1;
                  rd_idx_d    = '0;
                  out_valid_d = 1'b1;
                  out_data_d  = buf_rdata;
                  out_last_d  = (len_q == IDX_W'(1));
                  state_d     = ST_DRAIN;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            rx_overrun_d = rx_valid;
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  rd_idx_d   = rd_next;
                  out_data_d = buf_rdata;
                  out_last_d = (rd_next == len_q - IDX_W'(1));
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (tmo_expire) begin
         frame_err_d = 1'b1;
         state_d     = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         wr_idx_q     <= '0;
         rd_idx_q     <= '0;
         csum_q       <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_ok_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_overrun_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         wr_idx_q     <= wr_idx_d;
         rd_idx_q     <= rd_idx_d;
         csum_q       <= csum_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         frame_ok_q   <= frame_ok_d;
         frame_err_q  <= frame_err_d;
         rx_overrun_q <= rx_overrun_d;
         busy_q       <= (state_d != ST_IDLE);
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign frame_ok   = frame_ok_q;
   assign frame_err  = frame_err_q;
   assign rx_overrun = rx_overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed table, hand-timed corner sequences, random frames vs a parser model.
// Build with UART_FRAME_TIMEOUT_EN defined to exercise the inter-byte timeout.
module tb_uart_frame_rx;

   localparam int unsigned MAX_LEN = 16;
   localparam int unsigned TMO     = 100;

   typedef logic [7:0] bq_t[$];
   typedef logic [8:0] oq_t[$];

   typedef struct {
      logic [7:0] b [8];
      int         n;
      int         rmode;
      int         e_ok;
      int         e_err;
      logic [7:0] e_pay [4];
      int         e_n;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic       rx_overrun;
   logic       busy;

   int   checks = 0;
   int   failures = 0;
   oq_t  got;
   int   n_ok = 0, n_err = 0, n_ovr = 0;
   logic hold_prev = 1'b0;
   logic [8:0] hold_val = '0;
   int   ready_mode = 0;
   logic ready_val = 1'b1;

   uart_frame_rx #(
      .MAX_LEN        (MAX_LEN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err),
      .rx_overrun (rx_overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Consumer: fixed, random or alternating ready.
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       out_ready = ready_val;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = !out_ready;
      endcase
   end

   // Monitor: collect accepted bytes, count pulses, check stalled outputs stay put.
   always @(negedge clk) begin
      if (reset) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            checks++;
            if (!out_valid || {out_last, out_data} !== hold_val) begin
               failures++;
               $display("FAIL hold_stable: got valid=%b last/data=%h, required valid=1 last/data=%h",
                        out_valid, {out_last, out_data}, hold_val);
            end
         end
         if (frame_ok)   n_ok++;
         if (frame_err)  n_err++;
         if (rx_overrun) n_ovr++;
         if (out_valid && out_ready) got.push_back({out_last, out_data});
         hold_prev = out_valid && !out_ready;
         hold_val  = {out_last, out_data};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic cmp_q(input string name, input oq_t a, input oq_t e);
      int diff;
      diff = -1;
      for (int k = 0; k < a.size() && k < e.size(); k++)
         if (diff < 0 && a[k] !== e[k]) diff = k;
      checks++;
      if (a.size() != e.size() || diff >= 0) begin
         failures++;
         $display("FAIL %s: got %0d bytes, required %0d bytes, first differing index %0d",
                  name, a.size(), e.size(), diff);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      sync();
      rx_valid = 1'b0;
   endtask

   task automatic clear_obs();
      got   = {};
      n_ok  = 0;
      n_err = 0;
      n_ovr = 0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy && k < 500) begin
         sync();
         k++;
      end
      chk(name, 32'(busy), 32'd0);
      @(negedge clk);
      sync();
   endtask

   task automatic run_bytes(input bq_t s, input int gapmax);
      foreach (s[i]) begin
         send_byte(s[i]);
         repeat ($urandom_range(0, gapmax)) sync();
      end
      wait_idle("drain_done");
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      repeat (2) sync();
      reset = 1'b0;
   endtask

   // Reference parser over a byte stream starting in the idle state.
   function automatic void model(input bq_t s, output int e_ok, output int e_err, output oq_t e_q);
      int i, len;
      logic [7:0] x;
      i = 0;
      e_ok = 0;
      e_err = 0;
      e_q = {};
      while (i < s.size()) begin
         if (s[i] != 8'hA5) begin
            i++;
            continue;
         end
         if (i + 1 >= s.size()) break;
         len = int'(s[i+1]);
         if (len == 0 || len > int'(MAX_LEN)) begin
            e_err++;
            i += 2;
            continue;
         end
         if (i + 2 + len >= s.size()) break;
         x = s[i+1];
         for (int k = 0; k < len; k++) x ^= s[i+2+k];
         if (x == s[i+2+len]) begin
            e_ok++;
            for (int k = 0; k < len; k++) e_q.push_back({(k == len - 1), s[i+2+k]});
         end else begin
            e_err++;
         end
         i += len + 3;
      end
   endfunction

   vec_t vecs [7];

   initial begin
      bq_t s;
      oq_t e_q;
      int  e_ok, e_err, first;
      logic [7:0] x, len;

      vecs[0] = '{b:'{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h03,8'h00,8'h00}, n:6, rmode:0, e_ok:1, e_err:0,
                  e_pay:'{8'h11,8'h22,8'h33,8'h00}, e_n:3};
      vecs[1] = '{b:'{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h04,8'h00,8'h00}, n:6, rmode:0, e_ok:0, e_err:1,
                  e_pay:'{8'h00,8'h00,8'h00,8'h00}, e_n:0};
      vecs[2] = '{b:'{8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n:2, rmode:0, e_ok:0, e_err:1,
                  e_pay:'{8'h00,8'h00,8'h00,8'h00}, e_n:0};
      vecs[3] = '{b:'{8'hA5,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n:2, rmode:0, e_ok:0, e_err:1,
                  e_pay:'{8'h00,8'h00,8'h00,8'h00}, e_n:0};
      vecs[4] = '{b:'{8'hA5,8'h01,8'hA5,8'hA4,8'h00,8'h00,8'h00,8'h00}, n:4, rmode:0, e_ok:1, e_err:0,
                  e_pay:'{8'hA5,8'h00,8'h00,8'h00}, e_n:1};
      vecs[5] = '{b:'{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h03,8'h00,8'h00}, n:6, rmode:2, e_ok:1, e_err:0,
                  e_pay:'{8'h11,8'h22,8'h33,8'h00}, e_n:3};
      vecs[6] = '{b:'{8'h00,8'hFF,8'hA5,8'h02,8'hA5,8'h5A,8'hFD,8'h00}, n:7, rmode:0, e_ok:1, e_err:0,
                  e_pay:'{8'hA5,8'h5A,8'h00,8'h00}, e_n:2};

      reset_dut();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_frame_ok", 32'(frame_ok), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_rx_overrun", 32'(rx_overrun), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      sync();

      // Good frame, cycle-exact delivery with ready held high.
      ready_mode = 0;
      ready_val  = 1'b1;
      sync();
      clear_obs();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      chk("busy_mid_frame", 32'(busy), 32'd1);
      send_byte(8'h03);
      @(negedge clk);
      chk("ok_pulse", 32'(frame_ok), 32'd1);
      chk("first_valid", 32'(out_valid), 32'd1);
      chk("first_data", 32'(out_data), 32'h11);
      chk("first_last", 32'(out_last), 32'd0);
      @(negedge clk);
      chk("ok_one_cycle", 32'(frame_ok), 32'd0);
      chk("second_data", 32'(out_data), 32'h22);
      @(negedge clk);
      chk("third_data", 32'(out_data), 32'h33);
      chk("third_last", 32'(out_last), 32'd1);
      @(negedge clk);
      chk("drained_valid", 32'(out_valid), 32'd0);
      chk("drained_busy", 32'(busy), 32'd0);
      chk("good_no_err", 32'(n_err), 32'd0);
      sync();

      // Bad checksum: error one cycle after the strobe, nothing delivered.
      clear_obs();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h04);
      @(negedge clk);
      chk("badcs_err_pulse", 32'(frame_err), 32'd1);
      chk("badcs_no_valid", 32'(out_valid), 32'd0);
      sync();
      wait_idle("badcs_idle");
      chk("badcs_no_bytes", 32'(got.size()), 32'd0);

      // Overrun while draining under backpressure.
      ready_val = 1'b0;
      sync();
      clear_obs();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h03);
      sync();
      send_byte(8'h55);
      @(negedge clk);
      chk("ovr_pulse", 32'(rx_overrun), 32'd1);
      chk("ovr_valid_held", 32'(out_valid), 32'd1);
      chk("ovr_data_held", 32'(out_data), 32'h11);
      sync();
      ready_val = 1'b1;
      wait_idle("ovr_idle");
      e_q = {9'h011, 9'h022, 9'h133};
      cmp_q("ovr_payload", got, e_q);
      chk("ovr_count", 32'(n_ovr), 32'd1);

      // Reset in the middle of a drain.
      clear_obs();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h03);
      sync();
      reset = 1'b1;
      sync();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_last", 32'(out_last), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_pulses", 32'({frame_ok, frame_err, rx_overrun}), 32'd0);
      sync();

      // Directed table.
      for (int v = 0; v < 7; v++) begin
         s = {};
         for (int k = 0; k < vecs[v].n; k++) s.push_back(vecs[v].b[k]);
         e_q = {};
         for (int k = 0; k < vecs[v].e_n; k++) e_q.push_back({(k == vecs[v].e_n - 1), vecs[v].e_pay[k]});
         ready_mode = vecs[v].rmode;
         ready_val  = 1'b1;
         sync();
         clear_obs();
         run_bytes(s, 0);
         cmp_q($sformatf("vec%0d_payload", v), got, e_q);
         chk($sformatf("vec%0d_ok", v), 32'(n_ok), 32'(vecs[v].e_ok));
         chk($sformatf("vec%0d_err", v), 32'(n_err), 32'(vecs[v].e_err));
      end
      ready_mode = 0;
      ready_val  = 1'b1;
      sync();

`ifdef UART_FRAME_TIMEOUT_EN
      // Stalled frame: error exactly TMO cycles after the last strobe, then normal parsing.
      clear_obs();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
      first = 0;
      for (int k = 1; k <= 130; k++) begin
         @(negedge clk);
         if (frame_err && first == 0) first = k;
      end
      chk("tmo_latency", 32'(first), 32'(TMO));
      chk("tmo_err_count", 32'(n_err), 32'd1);
      chk("tmo_idle", 32'(busy), 32'd0);
      sync();
      clear_obs();
      s = {8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
      run_bytes(s, 0);
      e_q = {9'h012, 9'h134};
      cmp_q("tmo_next_payload", got, e_q);
      chk("tmo_next_ok", 32'(n_ok), 32'd1);
`else
      // Without the timeout a stalled frame simply waits.
      clear_obs();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
      repeat (150) @(negedge clk);
      chk("stall_no_err", 32'(n_err), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      sync();
      reset_dut();
      first = 0;
`endif

      // Random frames checked against the parser model.
      for (int f = 0; f < 40; f++) begin
         s = {};
         repeat ($urandom_range(0, 2)) begin
            x = 8'($urandom);
            if (x == 8'hA5) x = 8'h00;
            s.push_back(x);
         end
         s.push_back(8'hA5);
         if ($urandom_range(0, 9) == 0) begin
            s.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
         end else begin
            len = 8'($urandom_range(1, MAX_LEN));
            s.push_back(len);
            x = len;
            for (int k = 0; k < int'(len); k++) begin
               s.push_back(8'($urandom));
               x ^= s[s.size() - 1];
            end
            if ($urandom_range(0, 4) == 0) x ^= 8'($urandom_range(1, 255));
            s.push_back(x);
         end
         ready_mode = f % 2;
         sync();
         clear_obs();
         run_bytes(s, 2);
         model(s, e_ok, e_err, e_q);
         cmp_q($sformatf("rand%0d_payload", f), got, e_q);
         chk($sformatf("rand%0d_ok", f), 32'(n_ok), 32'(e_ok));
         chk($sformatf("rand%0d_err", f), 32'(n_err), 32'(e_err));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
